rr_mux_arbiter: RTL and testbench

- Shares one W-bit N:1 selection mux and one registered output slot between N requesters using round-robin arbitration with valid/ready handshakes.
- Supports locked multi-beat bursts: a requester asserting lock keeps the grant until a beat without lock.
- Sits between producer blocks and a single shared downstream consumer; it generates the mux select internally and exposes it as grant_id.

---
 rtl/rr_mux_arbiter.sv | 116 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 mux arbiter with valid/ready handshakes, locked bursts and
// a single registered output slot.
module rr_mux_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_lock,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [IW-1:0]   out_id,
  input  logic            out_ready,
  output logic [IW-1:0]   grant_id,
  output logic            locked
);

  generate
    if (N < 2 || N > 16 || IW < $clog2(N)) begin : g_bad_cfg
      $error("rr_mux_arbiter: invalid N/IW configuration");
    end
  endgenerate

  localparam int unsigned NU = N;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   lock_id, lock_id_n;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic            slot_free;
  logic            xfer;
  logic [W-1:0]    sel_data;
  int unsigned     scan_idx;

  // Winner search: locked state only considers lock_id; otherwise scan from ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    if (state == LOCKED) begin
      win_idx   = lock_id;
      win_found = req_valid[lock_id];
    end else begin
      for (int unsigned k = 0; k < NU; k++) begin
        scan_idx = (32'(ptr) + k) % NU;
        if (!win_found && req_valid[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = IW'(scan_idx);
        end
      end
    end
  end

  assign grant_id  = win_found ? win_idx : grant_q;
  assign slot_free = !out_valid || out_ready;
  assign xfer      = rst_n && slot_free && win_found;
  assign locked    = (state == LOCKED);
  assign sel_data  = req_data[int'(grant_id)*W +: W];

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    lock_id_n = lock_id;
    if (xfer) begin
      if (req_lock[win_idx]) begin
        state_n   = LOCKED;
        lock_id_n = win_idx;
      end else begin
        state_n = UNLOCKED;
        ptr_n   = IW'((32'(win_idx) + 1) % NU);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNLOCKED;
      ptr     <= '0;
      lock_id <= '0;
      grant_q <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      lock_id <= lock_id_n;
      grant_q <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_id    <= win_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: per-cycle comparison against a
// behavioural model plus directed literal expectations.
module tb_rr_mux_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_lock;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;
  logic           out_ready;
  logic [IW-1:0]  grant_id;
  logic           locked;

  int checks   = 0;
  int failures = 0;
  int tag      = 0;

  rr_mux_arbiter #(.N(N), .W(W), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_lock(req_lock), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready),
    .grant_id(grant_id), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state, described in terms of the arbitration rules.
  int         m_ptr, m_lock_id, m_grant, m_out_id;
  bit         m_locked, m_out_valid;
  logic [W-1:0] m_out_data;

  function automatic int model_winner(input logic [N-1:0] v, input bit lk,
                                      input int lid, input int p);
    if (lk) return v[lid] ? lid : -1;
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  int           exp_w, exp_grant;
  bit           exp_free;
  logic [N-1:0] exp_ready;

  always_comb begin
    exp_w     = model_winner(req_valid, m_locked, m_lock_id, m_ptr);
    exp_free  = !m_out_valid || out_ready;
    exp_grant = (exp_w >= 0) ? exp_w : m_grant;
    exp_ready = '0;
    if (exp_w >= 0 && exp_free) exp_ready[exp_w] = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_lock_id <= 0; m_grant <= 0; m_out_id <= 0;
      m_locked <= 0; m_out_valid <= 0; m_out_data <= '0;
    end else begin
      m_grant <= exp_grant;
      if (exp_w >= 0 && exp_free) begin
        m_out_valid <= 1;
        m_out_data  <= req_data[exp_w*W +: W];
        m_out_id    <= exp_w;
        if (req_lock[exp_w]) begin
          m_locked  <= 1;
          m_lock_id <= exp_w;
        end else begin
          m_locked <= 0;
          m_ptr    <= (exp_w + 1) % N;
        end
      end else if (m_out_valid && out_ready) begin
        m_out_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("grant_id",  int'(grant_id),  exp_grant);
      check("req_ready", int'(req_ready), int'(exp_ready));
      check("out_valid", int'(out_valid), int'(m_out_valid));
      check("out_data",  int'(out_data),  int'(m_out_data));
      check("out_id",    int'(out_id),    m_out_id);
      check("locked",    int'(locked),    int'(m_locked));
    end
  end

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    req_valid = v;
    req_lock  = l;
    out_ready = r;
    tag++;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'((tag % 16) * 16 + i);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int id, input int v, input int lk);
    check({name, ".out_id"},    int'(out_id),    id);
    check({name, ".out_valid"}, int'(out_valid), v);
    check({name, ".locked"},    int'(locked),    lk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_lock = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.out_data",  int'(out_data),  0);
    check("reset.req_ready", int'(req_ready), 0);
    rst_n = 1'b1;

    // Fairness: all valid, no lock
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("rr0", 0, 1, 0);
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("rr1", 1, 1, 0);
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("rr2", 2, 1, 0);
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("rr3", 3, 1, 0);
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("rr4", 0, 1, 0);

    // Move ptr to 3, then skip/wrap with 0101
    cyc(4'b0100, 4'b0000, 1'b1); expect_out("pset", 2, 1, 0);
    cyc(4'b0101, 4'b0000, 1'b1); expect_out("wrap0", 0, 1, 0);
    cyc(4'b0101, 4'b0000, 1'b1); expect_out("wrap1", 2, 1, 0);
    cyc(4'b0101, 4'b0000, 1'b1); expect_out("wrap2", 0, 1, 0);

    // Backpressure for 3 cycles, then drain and reload together
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111, 4'b0000, 1'b0);
      expect_out("bp", 0, 1, 0);
      check("bp.out_data", int'(out_data), (tag - i - 1) % 16 * 16 + 0);
    end
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("bp_reload", 1, 1, 0);

    // Locked burst from requester 2 (ptr=2)
    cyc(4'b1111, 4'b0100, 1'b1); expect_out("burst0", 2, 1, 1);
    cyc(4'b1111, 4'b0100, 1'b1); expect_out("burst1", 2, 1, 1);
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("burst2", 2, 1, 0);
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("after0", 3, 1, 0);
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("after1", 0, 1, 0);

    // Lock bubble on requester 1 (ptr=1)
    cyc(4'b0011, 4'b0010, 1'b1); expect_out("bub_lock", 1, 1, 1);
    cyc(4'b0001, 4'b0000, 1'b1); expect_out("bub0", 1, 0, 1);
    cyc(4'b0001, 4'b0000, 1'b1); expect_out("bub1", 1, 0, 1);
    cyc(4'b0011, 4'b0000, 1'b1); expect_out("bub_res", 1, 1, 0);
    cyc(4'b0001, 4'b0000, 1'b1); expect_out("bub_next", 0, 1, 0);

    // Reset mid-burst with a full slot
    cyc(4'b1111, 4'b1111, 1'b1); expect_out("pre_rst", 1, 1, 1);
    req_lock = 4'b0000;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.locked",    int'(locked),    0);
    check("rst.req_ready", int'(req_ready), 0);
    check("rst.out_id",    int'(out_id),    0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("post_rst0", 0, 1, 0);
    cyc(4'b1111, 4'b0000, 1'b1); expect_out("post_rst1", 1, 1, 0);
    cyc(4'b0000, 4'b0000, 1'b1); expect_out("idle", 1, 0, 0);
    cyc(4'b0000, 4'b0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
